// File: rtl/readout_pkg.sv
// Shared types and default sizing for the region readout sequencer.
// READOUT_CHECKSUM_EN (see region_readout_sequencer) uses the CHECKSUM state.
package readout_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    WAIT_RD   = 4'd2,
    LATCH     = 4'd3,
    SEND      = 4'd4,
    WAIT_ACK  = 4'd5,
    WAIT_DONE = 4'd6,
    CHECKSUM  = 4'd7,
    DONE      = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    REGION_WEIGHTS = 2'd0,
    REGION_PT      = 2'd1,
    REGION_SK      = 2'd2,
    REGION_B       = 2'd3
  } region_t;

  localparam int DEF_R0_DEPTH     = 25250;
  localparam int DEF_R1_DEPTH     = 25000;
  localparam int DEF_R2_DEPTH     = 50;
  localparam int DEF_R3_DEPTH     = 2500;
  localparam int DEF_R0_BYTES     = 4;
  localparam int DEF_R1_BYTES     = 1;
  localparam int DEF_R2_BYTES     = 1;
  localparam int DEF_R3_BYTES     = 4;
  localparam int DEF_READ_LATENCY = 2;

  // Byte idx of a 32-bit word; idx 0 is bits [7:0].
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/region_addr_decode.sv
// Combinational split of a global dump address into region select and local address.
// Zero-depth regions fall out of the boundary compares and are never selected.
module region_addr_decode
  import readout_pkg::*;
#(
  parameter int R0_DEPTH = DEF_R0_DEPTH,
  parameter int R1_DEPTH = DEF_R1_DEPTH,
  parameter int R2_DEPTH = DEF_R2_DEPTH,
  parameter int ADDR_W   = 16
) (
  input  logic [ADDR_W-1:0] gaddr,
  output region_t           sel,
  output logic [ADDR_W-1:0] laddr
);

  // One spare bit so a boundary equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] B1 = (ADDR_W+1)'(R0_DEPTH);
  localparam logic [ADDR_W:0] B2 = (ADDR_W+1)'(R0_DEPTH + R1_DEPTH);
  localparam logic [ADDR_W:0] B3 = (ADDR_W+1)'(R0_DEPTH + R1_DEPTH + R2_DEPTH);

  logic [ADDR_W:0] g;
  assign g = {1'b0, gaddr};

  always_comb begin
    sel   = REGION_WEIGHTS;
    laddr = gaddr;
    if (g < B1) begin
      sel   = REGION_WEIGHTS;
      laddr = gaddr;
    end else if (g < B2) begin
      sel   = REGION_PT;
      laddr = ADDR_W'(g - B1);
    end else if (g < B3) begin
      sel   = REGION_SK;
      laddr = ADDR_W'(g - B2);
    end else begin
      sel   = REGION_B;
      laddr = ADDR_W'(g - B3);
    end
  end

endmodule

// File: rtl/region_readout_sequencer.sv
// Walks all four parameter BRAM regions and streams every word MSB-first to uart_transmit.
// Define READOUT_CHECKSUM_EN to append a two's-complement mod-256 checksum byte.
module region_readout_sequencer
  import readout_pkg::*;
#(
  parameter int R0_DEPTH     = DEF_R0_DEPTH,
  parameter int R1_DEPTH     = DEF_R1_DEPTH,
  parameter int R2_DEPTH     = DEF_R2_DEPTH,
  parameter int R3_DEPTH     = DEF_R3_DEPTH,
  parameter int R0_BYTES     = DEF_R0_BYTES,
  parameter int R1_BYTES     = DEF_R1_BYTES,
  parameter int R2_BYTES     = DEF_R2_BYTES,
  parameter int R3_BYTES     = DEF_R3_BYTES,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  localparam int TOTAL       = R0_DEPTH + R1_DEPTH + R2_DEPTH + R3_DEPTH,
  localparam int ADDR_W      = $clog2(TOTAL)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              abort_in,
  output logic [ADDR_W-1:0] rd_addr_out,
  output logic [1:0]        rd_sel_out,
  input  logic [31:0]       rdata0_in,
  input  logic [31:0]       rdata1_in,
  input  logic [31:0]       rdata2_in,
  input  logic [31:0]       rdata3_in,
  output logic [7:0]        tx_byte_out,
  output logic              tx_valid_out,
  input  logic              tx_busy_in,
  output logic              busy_out,
  output logic              done_out
);

  localparam int                LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] gaddr_reg, gaddr_next;
  logic [LAT_W-1:0]  lat_reg, lat_next;
  logic [1:0]        idx_reg, idx_next;
  logic [31:0]       word_reg, word_next;
  logic [1:0]        rd_sel_next;
  logic [ADDR_W-1:0] rd_addr_next;
  logic [7:0]        tx_byte_next;

  region_t           dec_sel;
  logic [ADDR_W-1:0] dec_addr;
  logic [31:0]       rdata_mux;
  logic [1:0]        bytes_m1;
  logic [1:0]        idx_dec;

`ifdef READOUT_CHECKSUM_EN
  logic [7:0] sum_reg, sum_next;
  logic       csum_sent_reg, csum_sent_next;
`endif

  region_addr_decode #(
    .R0_DEPTH(R0_DEPTH),
    .R1_DEPTH(R1_DEPTH),
    .R2_DEPTH(R2_DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_decode (
    .gaddr(gaddr_reg),
    .sel  (dec_sel),
    .laddr(dec_addr)
  );

  always_comb begin
    rdata_mux = rdata0_in;
    bytes_m1  = 2'(R0_BYTES - 1);
    case (region_t'(rd_sel_out))
      REGION_WEIGHTS: begin rdata_mux = rdata0_in; bytes_m1 = 2'(R0_BYTES - 1); end
      REGION_PT:      begin rdata_mux = rdata1_in; bytes_m1 = 2'(R1_BYTES - 1); end
      REGION_SK:      begin rdata_mux = rdata2_in; bytes_m1 = 2'(R2_BYTES - 1); end
      REGION_B:       begin rdata_mux = rdata3_in; bytes_m1 = 2'(R3_BYTES - 1); end
      default:        begin rdata_mux = rdata0_in; bytes_m1 = 2'(R0_BYTES - 1); end
    endcase
  end

  assign idx_dec  = idx_reg - 2'd1;
  assign busy_out = (state_reg != IDLE) && (state_reg != DONE);
  assign done_out = (state_reg == DONE);

  always_comb begin
    state_next   = state_reg;
    gaddr_next   = gaddr_reg;
    lat_next     = lat_reg;
    idx_next     = idx_reg;
    word_next    = word_reg;
    rd_sel_next  = rd_sel_out;
    rd_addr_next = rd_addr_out;
    tx_byte_next = tx_byte_out;
    tx_valid_out = 1'b0;
`ifdef READOUT_CHECKSUM_EN
    sum_next       = sum_reg;
    csum_sent_next = csum_sent_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start_in) begin
          gaddr_next = '0;
          idx_next   = '0;
`ifdef READOUT_CHECKSUM_EN
          sum_next       = '0;
          csum_sent_next = 1'b0;
`endif
          state_next = ADDR;
        end
      end
      ADDR: begin
        rd_sel_next  = dec_sel;
        rd_addr_next = dec_addr;
        lat_next     = '0;
        state_next   = WAIT_RD;
      end
      WAIT_RD: begin
        if (lat_reg == LAT_LAST) state_next = LATCH;
        else                     lat_next   = lat_reg + 1'b1;
      end
      LATCH: begin
        // The byte register is loaded on entry to SEND so it is valid alongside tx_valid.
        word_next    = rdata_mux;
        idx_next     = bytes_m1;
        tx_byte_next = byte_of(rdata_mux, bytes_m1);
        state_next   = SEND;
      end
      SEND: begin
        if (!tx_busy_in) begin
          tx_valid_out = 1'b1;
`ifdef READOUT_CHECKSUM_EN
          sum_next = sum_reg + tx_byte_out;
`endif
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy_in) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy_in) begin
`ifdef READOUT_CHECKSUM_EN
          if (csum_sent_reg) begin
            state_next = DONE;
          end else
`endif
          if (idx_reg != 2'd0) begin
            idx_next     = idx_dec;
            tx_byte_next = byte_of(word_reg, idx_dec);
            state_next   = SEND;
          end else if (gaddr_reg == LAST_ADDR) begin
`ifdef READOUT_CHECKSUM_EN
            tx_byte_next = ~sum_reg + 8'd1;
            state_next   = CHECKSUM;
`else
            state_next   = DONE;
`endif
          end else begin
            gaddr_next = gaddr_reg + 1'b1;
            state_next = ADDR;
          end
        end
      end
`ifdef READOUT_CHECKSUM_EN
      CHECKSUM: begin
        if (!tx_busy_in) begin
          tx_valid_out   = 1'b1;
          csum_sent_next = 1'b1;
          state_next     = WAIT_ACK;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Abort wins over everything; an in-flight UART byte simply runs out on its own.
    if (abort_in && (state_reg != IDLE) && (state_reg != DONE)) begin
      state_next   = DONE;
      tx_valid_out = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg   <= IDLE;
      gaddr_reg   <= '0;
      lat_reg     <= '0;
      idx_reg     <= '0;
      word_reg    <= '0;
      rd_sel_out  <= '0;
      rd_addr_out <= '0;
      tx_byte_out <= '0;
    end else begin
      state_reg   <= state_next;
      gaddr_reg   <= gaddr_next;
      lat_reg     <= lat_next;
      idx_reg     <= idx_next;
      word_reg    <= word_next;
      rd_sel_out  <= rd_sel_next;
      rd_addr_out <= rd_addr_next;
      tx_byte_out <= tx_byte_next;
    end
  end

`ifdef READOUT_CHECKSUM_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sum_reg       <= '0;
      csum_sent_reg <= 1'b0;
    end else begin
      sum_reg       <= sum_next;
      csum_sent_reg <= csum_sent_next;
    end
  end
`endif

endmodule

// File: tb/tb_region_readout_sequencer.sv
// Scoreboard bench: two sequencers (region 2 depth 1 and depth 0) dump a small memory to a UART model.
// Expected bytes come from a region/word/byte walk of the memory, independent of the sequencer's address logic.
module tb_region_readout_sequencer;

  localparam int AW = 3;

  typedef struct packed {
    logic [7:0]    b;
    logic [1:0]    sel;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic force_busy = 1'b0;

  logic [AW-1:0] rd_addr  [2];
  logic [1:0]    rd_sel   [2];
  logic [7:0]    tx_byte  [2];
  logic          tx_valid [2];
  logic          tx_busy  [2];
  logic          busy     [2];
  logic          done     [2];

  logic [31:0] mem [4][8];

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   exp_len   [2];
  int   seen      [2] = '{0, 0};
  int   dones     [2] = '{0, 0};
  int   seen_base [2];
  int   done_base [2];
  logic armed     [2] = '{1'b1, 1'b1};
  logic prev_busy [2] = '{1'b0, 1'b0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [31:0] q1 [4];
    logic [31:0] q2 [4];
    int          hold;

    region_readout_sequencer #(
      .R0_DEPTH(3), .R1_DEPTH(2), .R2_DEPTH((gi == 0) ? 1 : 0), .R3_DEPTH(2),
      .R0_BYTES(4), .R1_BYTES(1), .R2_BYTES(1), .R3_BYTES(4),
      .READ_LATENCY(2)
    ) dut (
      .clk_in      (clk),
      .rst_in      (rst),
      .start_in    (start),
      .abort_in    (abort),
      .rd_addr_out (rd_addr[gi]),
      .rd_sel_out  (rd_sel[gi]),
      .rdata0_in   (q2[0]),
      .rdata1_in   (q2[1]),
      .rdata2_in   (q2[2]),
      .rdata3_in   (q2[3]),
      .tx_byte_out (tx_byte[gi]),
      .tx_valid_out(tx_valid[gi]),
      .tx_busy_in  (tx_busy[gi]),
      .busy_out    (busy[gi]),
      .done_out    (done[gi])
    );

    // Two-stage BRAM read: address register then output register.
    always @(posedge clk) begin
      for (int r = 0; r < 4; r++) begin
        q1[r] <= mem[r][rd_addr[gi]];
        q2[r] <= q1[r];
      end
    end

    // UART model: busy from the cycle after the trigger, for 10 cycles.
    always @(posedge clk or posedge rst) begin
      if (rst)                 hold <= 0;
      else if (tx_valid[gi])   hold <= 10;
      else if (hold != 0)      hold <= hold - 1;
    end
    assign tx_busy[gi] = (hold != 0) || force_busy;
  end

  // Monitor: pops one expectation per transmitted byte.
  always @(negedge clk) begin
    for (int gi = 0; gi < 2; gi++) begin
      if (tx_valid[gi]) begin
        exp_t e;
        logic empty;
        seen[gi]++;
        checks++;
        if (tx_busy[gi]) begin
          errors++;
          $display("FAIL valid_while_busy dut%0d: tx_valid=1 with tx_busy=1, required busy=0", gi);
        end
        checks++;
        if (!armed[gi]) begin
          errors++;
          $display("FAIL double_pulse dut%0d: second tx_valid without busy high->low", gi);
        end
        armed[gi] = 1'b0;
        empty = (gi == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        checks++;
        if (empty) begin
          errors++;
          $display("FAIL unexpected_byte dut%0d: got %02h, required no byte", gi, tx_byte[gi]);
        end else begin
          if (gi == 0) e = exp_q0.pop_front();
          else         e = exp_q1.pop_front();
          if (tx_byte[gi] !== e.b || rd_sel[gi] !== e.sel || rd_addr[gi] !== e.addr) begin
            errors++;
            $display("FAIL byte dut%0d: got byte %02h sel %0d addr %0d, required byte %02h sel %0d addr %0d",
                     gi, tx_byte[gi], rd_sel[gi], rd_addr[gi], e.b, e.sel, e.addr);
          end else begin
            $display("dut%0d tx byte %02h sel %0d addr %0d", gi, tx_byte[gi], rd_sel[gi], rd_addr[gi]);
          end
        end
      end
      if (prev_busy[gi] && !tx_busy[gi]) armed[gi] = 1'b1;
      prev_busy[gi] = tx_busy[gi];
      if (done[gi]) dones[gi]++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end else begin
      $display("check %s = %0h", name, got);
    end
  endtask

  // mode 0: random, 1: every byte 0x01, 2: random with directed R0[0] and R1[1]
  task automatic load_mem(input int mode);
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 8; a++) begin
        logic [31:0] w;
        w = $urandom;
        if (r == 1 || r == 2) w = w & 32'h3;
        if (mode == 1) w = (r == 1 || r == 2) ? 32'h1 : 32'h01010101;
        mem[r][a] = w;
      end
    end
    if (mode == 2) begin
      mem[0][0] = 32'hDEADBEEF;
      mem[1][1] = 32'h3;
    end
  endtask

  // Reference: walk regions in order, words in order, bytes MSB first.
  task automatic push_expected();
    int nb [4];
    nb = '{4, 1, 1, 4};
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) begin
      int   depth [4];
      int   sum;
      int   cnt;
      exp_t e;
      depth = '{3, 2, (d == 0) ? 1 : 0, 2};
      sum = 0;
      cnt = 0;
      for (int r = 0; r < 4; r++) begin
        for (int a = 0; a < depth[r]; a++) begin
          for (int b = nb[r] - 1; b >= 0; b--) begin
            e.b    = 8'(mem[r][a] >> (8 * b));
            e.sel  = 2'(r);
            e.addr = AW'(a);
            if (d == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
            sum += int'(e.b);
            cnt++;
          end
        end
      end
`ifdef READOUT_CHECKSUM_EN
      e.b    = 8'((256 - (sum % 256)) % 256);
      e.sel  = 2'd3;
      e.addr = AW'(1);
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      cnt++;
`endif
      exp_len[d] = cnt;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic start_dump(input int mode);
    load_mem(mode);
    push_expected();
    for (int gi = 0; gi < 2; gi++) begin
      seen_base[gi] = seen[gi];
      done_base[gi] = dones[gi];
    end
    pulse_start();
  endtask

  task automatic wait_seen(input string name, input int target);
    int k = 0;
    while (seen[0] < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_wait_timeout"}, 32'(k >= 2000), 32'd0);
  endtask

  task automatic finish_dump(input string name);
    int k = 0;
    while ((dones[0] == done_base[0] || dones[1] == done_base[1]) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done_timeout"}, 32'(k >= 5000), 32'd0);
    repeat (5) @(negedge clk);
    check({name, "_done_pulses0"}, 32'(dones[0] - done_base[0]), 32'd1);
    check({name, "_done_pulses1"}, 32'(dones[1] - done_base[1]), 32'd1);
    check({name, "_bytes0"}, 32'(seen[0] - seen_base[0]), 32'(exp_len[0]));
    check({name, "_bytes1"}, 32'(seen[1] - seen_base[1]), 32'(exp_len[1]));
    check({name, "_leftover0"}, 32'(exp_q0.size()), 32'd0);
    check({name, "_leftover1"}, 32'(exp_q1.size()), 32'd0);
    check({name, "_busy_low"}, 32'(busy[0]), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_tx_valid", 32'(tx_valid[0]), 32'd0);
    check("rst_tx_byte", 32'(tx_byte[0]), 32'd0);
    check("rst_rd_sel", 32'(rd_sel[0]), 32'd0);
    check("rst_rd_addr", 32'(rd_addr[0]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Directed full dump (DEADBEEF first, region-1 word 3)
    start_dump(2);
    finish_dump("full");

    // Busy held high at start; a start pulse mid-dump must be ignored
    #1 force_busy = 1'b1;
    start_dump(0);
    repeat (50) @(negedge clk);
    check("forced_busy_no_valid", 32'(seen[0] - seen_base[0]), 32'd0);
    @(posedge clk); #1 force_busy = 1'b0;
    wait_seen("hs", seen_base[0] + 8);
    pulse_start();
    finish_dump("handshake");

    // Abort after the fifth byte, then restart from address 0
    start_dump(0);
    wait_seen("abort", seen_base[0] + 5);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_done_pulses", 32'(dones[0] - done_base[0]), 32'd1);
    check("abort_busy_low", 32'(busy[0]), 32'd0);
    check("abort_bytes", 32'(seen[0] - seen_base[0]), 32'd5);
    start_dump(0);
    finish_dump("restart");

    // Asynchronous reset while waiting for the UART to finish
    start_dump(0);
    wait_seen("rstmid", seen_base[0] + 3);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("amid_busy", 32'(busy[0]), 32'd0);
    check("amid_done", 32'(done[0]), 32'd0);
    check("amid_tx_valid", 32'(tx_valid[0]), 32'd0);
    check("amid_tx_byte", 32'(tx_byte[0]), 32'd0);
    check("amid_rd_sel", 32'(rd_sel[0]), 32'd0);
    check("amid_rd_addr", 32'(rd_addr[0]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    check("amid_no_done", 32'(dones[0] - done_base[0]), 32'd0);
    check("amid_no_bytes", 32'(seen[0] - seen_base[0]), 32'd3);
    exp_q0.delete();
    exp_q1.delete();

    // Every byte 0x01 (checksum case when enabled)
    start_dump(1);
    finish_dump("ones");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
